// File: rtl/spi_arbiter.sv
// Round-robin arbiter sharing one SPI master among NUM_REQ requesters.
// One byte per grant, optional lock for bursts, watchdog abort on a stalled transfer.
module spi_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 4096
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [8*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     lock,
    output logic [NUM_REQ-1:0]     gnt,
    output logic [NUM_REQ-1:0]     done,
    output logic [7:0]             rx_data,
    output logic                   timeout_err,
    output logic                   busy,
    output logic                   m_spi_enable,
    output logic [7:0]             m_data_in,
    input  logic                   m_cs,
    input  logic [7:0]             m_data_out
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int WW = $clog2(TIMEOUT);
    // Abort is registered on the edge where the count reaches TIMEOUT-1.
    localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 2);
    localparam logic [PW-1:0] PTR_MAX = PW'(NUM_REQ - 1);

    typedef enum logic [1:0] {IDLE, WAIT_LOW, WAIT_HIGH, FINISH} state_t;

    state_t               state, state_n;
    logic [PW-1:0]        ptr, ptr_n, win, win_n, pick, idx, win_inc;
    logic                 found;
    logic [WW-1:0]        wd, wd_n;
    logic [NUM_REQ-1:0]   gnt_n, done_n;
    logic [7:0]           rx_n, din_n;
    logic                 te_n, en_n;

    assign busy    = (state != IDLE);
    assign win_inc = (win == PTR_MAX) ? '0 : win + 1'b1;

    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = PW'((int'(ptr) + i) % NUM_REQ);
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        win_n   = win;
        wd_n    = wd;
        gnt_n   = gnt;
        done_n  = '0;
        rx_n    = rx_data;
        te_n    = 1'b0;
        en_n    = 1'b0;
        din_n   = m_data_in;
        case (state)
            IDLE: begin
                if (found) begin
                    win_n   = pick;
                    gnt_n   = NUM_REQ'(1) << pick;
                    din_n   = req_data[{pick, 3'b000} +: 8];
                    en_n    = 1'b1;
                    wd_n    = '0;
                    state_n = WAIT_LOW;
                end
            end
            WAIT_LOW, WAIT_HIGH: begin
                wd_n = wd + 1'b1;
                if (state == WAIT_LOW && !m_cs) begin
                    state_n = WAIT_HIGH;
                end else if (state == WAIT_HIGH && m_cs) begin
                    state_n = FINISH;
                end else if (wd >= WD_LAST) begin
                    te_n    = 1'b1;
                    gnt_n   = '0;
                    ptr_n   = win_inc;
                    state_n = IDLE;
                end
            end
            FINISH: begin
                rx_n   = m_data_out;
                done_n = gnt;
                if (lock[win] && req[win]) begin
                    din_n   = req_data[{win, 3'b000} +: 8];
                    en_n    = 1'b1;
                    wd_n    = '0;
                    state_n = WAIT_LOW;
                end else begin
                    gnt_n   = '0;
                    ptr_n   = win_inc;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            ptr          <= '0;
            win          <= '0;
            wd           <= '0;
            gnt          <= '0;
            done         <= '0;
            rx_data      <= '0;
            timeout_err  <= 1'b0;
            m_spi_enable <= 1'b0;
            m_data_in    <= '0;
        end else begin
            state        <= state_n;
            ptr          <= ptr_n;
            win          <= win_n;
            wd           <= wd_n;
            gnt          <= gnt_n;
            done         <= done_n;
            rx_data      <= rx_n;
            timeout_err  <= te_n;
            m_spi_enable <= en_n;
            m_data_in    <= din_n;
        end
    end

endmodule

// File: tb/tb_spi_arbiter.sv
// Bench for spi_arbiter: transaction-level round-robin model plus a simple
// SPI slave responder; each scenario task checks its own observations.
module tb_spi_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  lock = '0;
    logic [3:0]  gnt, done;
    logic [7:0]  rx_data, m_data_in;
    logic        timeout_err, busy, m_spi_enable;
    logic        m_cs = 1'b1;
    logic [7:0]  m_data_out = '0;

    int          n_tests = 0;
    int          n_fail = 0;
    int          mptr = 0;
    logic [7:0]  last_rx = '0;

    spi_arbiter #(.NUM_REQ(4), .TIMEOUT(64)) dut (
        .clk(clk), .reset(reset), .req(req), .req_data(req_data), .lock(lock),
        .gnt(gnt), .done(done), .rx_data(rx_data), .timeout_err(timeout_err),
        .busy(busy), .m_spi_enable(m_spi_enable), .m_data_in(m_data_in),
        .m_cs(m_cs), .m_data_out(m_data_out)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    function automatic int rr_pick(logic [3:0] r, int p);
        for (int k = 0; k < 4; k++)
            if (r[(p + k) % 4]) return (p + k) % 4;
        return -1;
    endfunction

    function automatic logic [7:0] byte_of(logic [31:0] v, int i);
        return v[8*i +: 8];
    endfunction

    // Slave responder: waits for a launch, records what was launched, runs the
    // cs low/high handshake and reports when done appears and what it carried.
    task automatic serve(input logic [7:0] rx, input logic [3:0] drop,
                         input logic [31:0] nxt_data, input logic [3:0] nxt_lock,
                         output logic [3:0] o_gnt, output logic [7:0] o_din,
                         output logic o_en2, output int o_wait,
                         output logic [3:0] o_done, output logic [7:0] o_rx,
                         output int o_lat, output logic o_busy);
        o_gnt = 'x; o_din = 'x; o_en2 = 1'bx; o_wait = 0;
        o_done = '0; o_rx = 'x; o_lat = -1; o_busy = 1'bx;
        while (!m_spi_enable && o_wait < 20) begin
            @(negedge clk);
            o_wait++;
        end
        o_gnt  = gnt;
        o_din  = m_data_in;
        o_busy = busy;
        if (!m_spi_enable) return;
        req = req & ~drop;
        @(negedge clk);
        o_en2 = m_spi_enable;
        repeat ($urandom_range(0, 3)) @(negedge clk);
        m_cs = 1'b0;
        repeat ($urandom_range(1, 4)) @(negedge clk);
        m_data_out = rx;
        m_cs = 1'b1;
        req_data = nxt_data;
        lock = nxt_lock;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (done != 0) begin
                o_lat  = k;
                o_done = done;
                o_rx   = rx_data;
                break;
            end
        end
        m_data_out = 8'($urandom);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({gnt, done, rx_data, timeout_err, busy, m_spi_enable, m_data_in} !== 27'd0) begin
            n_fail++;
            $display("FAIL reset_values: gnt=%b done=%b rx=%h te=%b busy=%b en=%b din=%h, expected all zero",
                     gnt, done, rx_data, timeout_err, busy, m_spi_enable, m_data_in);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({busy, m_spi_enable, gnt} !== 6'd0) begin
            n_fail++;
            $display("FAIL idle_no_req: busy=%b en=%b gnt=%b, expected 0 0 0000", busy, m_spi_enable, gnt);
        end
        mptr = 0;
        last_rx = '0;
    endtask

    task automatic test_single;
        logic [3:0] g, d; logic [7:0] di, rx; logic e2, b; int w, l;
        req_data[7:0] = 8'hE6;
        req = 4'b0001;
        serve(8'h03, 4'b0000, req_data, lock, g, di, e2, w, d, rx, l, b);
        req = 4'b0000;
        n_tests++;
        if ({g, di, e2, b} !== {4'b0001, 8'hE6, 1'b0, 1'b1} || w != 1) begin
            n_fail++;
            $display("FAIL single_launch: gnt=%b din=%h en2=%b busy=%b wait=%0d, expected 0001 e6 0 1 1", g, di, e2, b, w);
        end
        n_tests++;
        if ({d, rx} !== {4'b0001, 8'h03} || l != 2 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_done: done=%b rx=%h lat=%0d busy=%b, expected 0001 03 2 0", d, rx, l, busy);
        end
        @(negedge clk);
        n_tests++;
        if ({done, m_spi_enable, busy, gnt} !== 10'd0 || rx_data !== 8'h03) begin
            n_fail++;
            $display("FAIL single_after: done=%b en=%b busy=%b gnt=%b rx=%h, expected 0000 0 0 0000 03",
                     done, m_spi_enable, busy, gnt, rx_data);
        end
        mptr = 1;
        last_rx = 8'h03;
    endtask

    task automatic test_round_robin;
        logic [3:0] g, d, eg; logic [7:0] di, rx, erx; logic e2, b; int w, l, ew;
        req_data = {8'h00, 8'hC3, 8'h00, 8'h0F};
        req = 4'b0101;
        for (int i = 0; i < 4; i++) begin
            ew = rr_pick(req, mptr);
            eg = 4'(1 << ew);
            erx = 8'($urandom);
            serve(erx, 4'b0000, req_data, lock, g, di, e2, w, d, rx, l, b);
            if (i == 3) req = 4'b0000;
            n_tests++;
            if ({g, di, d, rx} !== {eg, byte_of(req_data, ew), eg, erx} || w != 1 || l != 2 || e2 !== 1'b0) begin
                n_fail++;
                $display("FAIL rr_byte%0d: gnt=%b din=%h done=%b rx=%h wait=%0d lat=%0d, expected %b %h %b %h 1 2",
                         i, g, di, d, rx, w, l, eg, byte_of(req_data, ew), eg, erx);
            end
            mptr = (ew + 1) % 4;
            last_rx = erx;
        end
        @(negedge clk);
    endtask

    task automatic test_random_back_to_back;
        logic [3:0] g, d, eg; logic [7:0] di, rx, erx; logic e2, b; int w, l, ew;
        req = 4'($urandom_range(1, 15));
        for (int i = 0; i < 16; i++) begin
            req_data = $urandom;
            ew = rr_pick(req, mptr);
            eg = 4'(1 << ew);
            erx = 8'($urandom);
            serve(erx, 4'b0000, req_data, lock, g, di, e2, w, d, rx, l, b);
            req = (i == 15) ? 4'b0000 : 4'($urandom_range(1, 15));
            n_tests++;
            if ({g, di, d, rx} !== {eg, byte_of(req_data, ew), eg, erx} || w != 1 || l != 2) begin
                n_fail++;
                $display("FAIL random_%0d: gnt=%b din=%h done=%b rx=%h wait=%0d lat=%0d, expected %b %h %b %h 1 2",
                         i, g, di, d, rx, w, l, eg, byte_of(req_data, ew), eg, erx);
            end
            mptr = (ew + 1) % 4;
            last_rx = erx;
        end
        @(negedge clk);
    endtask

    task automatic test_lock;
        logic [3:0] g, d; logic [7:0] di, rx, erx; logic e2, b; int w, l, ew;
        logic [7:0] bytes [3];
        bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33;
        req_data = {8'h00, 8'h11, 8'h00, 8'h5A};
        lock = 4'b0100;
        req = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            erx = 8'($urandom);
            serve(erx, 4'b0000,
                  {8'h00, (i < 2) ? bytes[i+1] : bytes[2], 8'h00, 8'h5A},
                  (i < 2) ? 4'b0100 : 4'b0000,
                  g, di, e2, w, d, rx, l, b);
            if (i == 0) req = 4'b0101;
            n_tests++;
            if ({g, di, d, rx} !== {4'b0100, bytes[i], 4'b0100, erx} || w != ((i == 0) ? 1 : 0) || l != 2) begin
                n_fail++;
                $display("FAIL lock_byte%0d: gnt=%b din=%h done=%b rx=%h wait=%0d lat=%0d, expected 0100 %h 0100 %h %0d 2",
                         i, g, di, d, rx, w, l, bytes[i], erx, (i == 0) ? 1 : 0);
            end
            last_rx = erx;
        end
        mptr = 3;
        req = 4'b0001;
        ew = rr_pick(req, mptr);
        erx = 8'($urandom);
        serve(erx, 4'b0000, req_data, lock, g, di, e2, w, d, rx, l, b);
        req = 4'b0000;
        n_tests++;
        if ({g, di, d, rx} !== {4'b0001, 8'h5A, 4'b0001, erx} || w != 1) begin
            n_fail++;
            $display("FAIL lock_release: gnt=%b din=%h done=%b rx=%h wait=%0d, expected 0001 5a 0001 %h 1",
                     g, di, d, rx, w, erx);
        end
        mptr = (ew + 1) % 4;
        last_rx = erx;
        @(negedge clk);
    endtask

    task automatic test_watchdog;
        logic [3:0] g, d, eg; logic [7:0] di, rx, erx; logic e2, b, saw_done; int w, l, ew, cnt;
        req_data = $urandom;
        req = 4'b1010;
        m_cs = 1'b1;
        ew = rr_pick(req, mptr);
        cnt = 0;
        while (!m_spi_enable && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        n_tests++;
        if (gnt !== 4'(1 << ew) || m_spi_enable !== 1'b1) begin
            n_fail++;
            $display("FAIL wd_launch: gnt=%b en=%b, expected %b 1", gnt, m_spi_enable, 4'(1 << ew));
        end
        cnt = 0;
        saw_done = 1'b0;
        while (cnt < 200) begin
            @(negedge clk);
            cnt++;
            if (done != 0) saw_done = 1'b1;
            if (timeout_err) break;
        end
        n_tests++;
        if (cnt != 63 || saw_done !== 1'b0 || gnt !== 4'b0000 || rx_data !== last_rx) begin
            n_fail++;
            $display("FAIL wd_abort: cycles=%0d done_seen=%b gnt=%b rx=%h, expected 63 0 0000 %h",
                     cnt, saw_done, gnt, rx_data, last_rx);
        end
        req = req & ~4'(1 << ew);
        mptr = (ew + 1) % 4;
        @(negedge clk);
        n_tests++;
        if (timeout_err !== 1'b0) begin
            n_fail++;
            $display("FAIL wd_pulse_width: timeout_err=%b one cycle after abort, expected 0", timeout_err);
        end
        ew = rr_pick(req, mptr);
        eg = 4'(1 << ew);
        erx = 8'($urandom);
        serve(erx, 4'b0000, req_data, lock, g, di, e2, w, d, rx, l, b);
        req = 4'b0000;
        n_tests++;
        if ({g, di, d, rx} !== {eg, byte_of(req_data, ew), eg, erx} || l != 2) begin
            n_fail++;
            $display("FAIL wd_next: gnt=%b din=%h done=%b rx=%h lat=%0d, expected %b %h %b %h 2",
                     g, di, d, rx, l, eg, byte_of(req_data, ew), eg, erx);
        end
        mptr = (ew + 1) % 4;
        last_rx = erx;
        @(negedge clk);
    endtask

    task automatic test_early_drop;
        logic [3:0] g, d; logic [7:0] di, rx, erx; logic e2, b; int w, l;
        req_data = $urandom;
        lock = 4'b1000;
        req = 4'b1000;
        erx = 8'($urandom);
        serve(erx, 4'b1000, req_data, lock, g, di, e2, w, d, rx, l, b);
        n_tests++;
        if ({g, di, d, rx} !== {4'b1000, req_data[31:24], 4'b1000, erx} || l != 2) begin
            n_fail++;
            $display("FAIL early_drop_done: gnt=%b din=%h done=%b rx=%h lat=%0d, expected 1000 %h 1000 %h 2",
                     g, di, d, rx, l, req_data[31:24], erx);
        end
        @(negedge clk);
        n_tests++;
        if ({busy, m_spi_enable, gnt, done} !== 10'd0) begin
            n_fail++;
            $display("FAIL early_drop_idle: busy=%b en=%b gnt=%b done=%b, expected 0 0 0000 0000",
                     busy, m_spi_enable, gnt, done);
        end
        lock = 4'b0000;
        mptr = 0;
        last_rx = erx;
    endtask

    task automatic test_reset_mid;
        logic [3:0] g, d; logic [7:0] di, rx, erx; logic e2, b; int w, l, cnt;
        req_data = $urandom;
        req = 4'b0100;
        cnt = 0;
        while (!m_spi_enable && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        @(negedge clk);
        m_cs = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++;
        if (busy !== 1'b1 || gnt !== 4'b0100) begin
            n_fail++;
            $display("FAIL mid_pre_reset: busy=%b gnt=%b, expected 1 0100", busy, gnt);
        end
        reset = 1'b1;
        #1;
        n_tests++;
        if ({gnt, done, rx_data, timeout_err, busy, m_spi_enable, m_data_in} !== 27'd0) begin
            n_fail++;
            $display("FAIL mid_reset: gnt=%b done=%b rx=%h te=%b busy=%b en=%b din=%h, expected all zero",
                     gnt, done, rx_data, timeout_err, busy, m_spi_enable, m_data_in);
        end
        m_cs = 1'b1;
        @(negedge clk);
        req = 4'b0000;
        reset = 1'b0;
        mptr = 0;
        last_rx = '0;
        @(negedge clk);
        n_tests++;
        if ({done, busy} !== 5'd0) begin
            n_fail++;
            $display("FAIL mid_after_release: done=%b busy=%b, expected 0000 0", done, busy);
        end
        req = 4'b0010;
        erx = 8'($urandom);
        serve(erx, 4'b0000, req_data, lock, g, di, e2, w, d, rx, l, b);
        req = 4'b0000;
        n_tests++;
        if ({g, di, d, rx} !== {4'b0010, req_data[15:8], 4'b0010, erx} || w != 1 || l != 2) begin
            n_fail++;
            $display("FAIL mid_fresh: gnt=%b din=%h done=%b rx=%h wait=%0d lat=%0d, expected 0010 %h 0010 %h 1 2",
                     g, di, d, rx, w, l, req_data[15:8], erx);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_random_back_to_back();
        test_lock();
        test_watchdog();
        test_early_drop();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_arbiter.md
Name: spi_arbiter

Overview:
- Shares one SPI master between NUM_REQ requesters; grants one requester at a time and runs one byte transfer per grant.
- Arbitration is round-robin; a lock option keeps the grant for multi-byte bursts.
- Sequences the master: drives its spi_enable and data_in, watches cs to detect transfer completion, returns data_out to the granted requester.
- A watchdog aborts a transfer that stalls.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT, 4096, maximum clk cycles from launch to cs rising before abort.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- req  in  NUM_REQ  per-requester transfer request, level.
- req_data  in  8*NUM_REQ  TX byte per requester; requester i uses bits [8i+7:8i].
- lock  in  NUM_REQ  1 = keep grant after this byte if req stays high.
- gnt  out  NUM_REQ  one-hot grant, registered.
- done  out  NUM_REQ  one-cycle pulse to the granted requester when its byte completes.
- rx_data  out  8  received byte; valid in the done cycle and held until the next done.
- timeout_err  out  1  one-cycle pulse on watchdog abort.
- busy  out  1  high whenever state is not IDLE.
- m_spi_enable  out  1  start pulse to the master.
- m_data_in  out  8  TX byte to the master; held stable for the whole transfer.
- m_cs  in  1  master chip select, active-low; same clock domain, used without synchronisation.
- m_data_out  in  8  master RX byte.

Behaviour:
- Reset values: gnt=0, done=0, rx_data=0, timeout_err=0, busy=0, m_spi_enable=0, m_data_in=0, RR pointer=0, watchdog=0, state=IDLE.
- Reset mid-transfer aborts immediately; no done is issued.
- States: IDLE, WAIT_LOW, WAIT_HIGH, FINISH.
- IDLE, when any req is high, at the next edge:
  - winner = first set req bit at or after the pointer, wrapping.
  - gnt <= onehot(winner); m_data_in <= req_data[winner]; m_spi_enable <= 1; watchdog cleared; go to WAIT_LOW.
- m_spi_enable is high for exactly one cycle per launch.
- WAIT_LOW: m_cs == 0 -> WAIT_HIGH.
- WAIT_HIGH: m_cs == 1 -> FINISH.
- FINISH (one cycle; outputs registered at its exit edge):
  - rx_data <= m_data_out; done[winner] <= 1.
  - If lock[winner] && req[winner]: relaunch the same requester (m_data_in <= req_data[winner], m_spi_enable <= 1, watchdog cleared, go to WAIT_LOW). gnt is unchanged and the pointer does not move.
  - Otherwise: gnt <= 0; pointer <= winner+1 mod NUM_REQ; go to IDLE.
- Latency:
  - req high in IDLE -> gnt and m_spi_enable high 1 cycle later.
  - m_cs rising edge -> done 2 cycles later.
  - Back-to-back across requesters: one IDLE cycle between FINISH and the next launch.
- Requester contract:
  - Hold req and req_data until done.
  - Dropping req early does not cancel an in-flight byte; done still pulses.
  - Data changes after launch are ignored.
- Watchdog:
  - Counts every cycle in WAIT_LOW and WAIT_HIGH.
  - On reaching TIMEOUT-1: timeout_err pulse, gnt <= 0, no done, rx_data unchanged, pointer advances past the winner, go to IDLE.
- m_cs already low at launch is accepted; WAIT_LOW exits on the next cycle.
- Lock from a requester with req low is ignored.
- Counter width: clog2(TIMEOUT).

Test Plan:
- Single request: req=0001, req_data[7:0]=0xE6, slave returns 0x03 -> gnt=0001 and a single m_spi_enable pulse with m_data_in=0xE6; done=0001 exactly once; rx_data=0x03; busy falls after FINISH.
- Round-robin: req=0101 held, lock=0, data 0x0F/0xC3 -> grants alternate 0001, 0100, 0001, 0100; each done matches its grant; requester 1 is never granted.
- Burst lock: req[2]=1 and lock[2]=1 for 3 bytes (0x11, 0x22, 0x33) while req[0]=1 -> gnt stays 0100 with three done pulses; requester 0 is granted only after lock drops.
- Watchdog: m_cs held high after launch, TIMEOUT=64 -> timeout_err pulses 63 cycles after launch; no done; gnt=0; next pending requester is granted.
- Reset mid-transfer: assert reset while in WAIT_HIGH -> all outputs immediately 0 with no done; a fresh request afterward completes normally.
- Early req drop: req[3] deasserted during WAIT_LOW -> transfer completes, done[3] pulses, then IDLE.
